// File: rtl/pulse_pkg.sv
// Shared constants for the pulses generator and its host-side parameter loader:
// register map, flag bits, reset defaults, frame bytes and the loader FSM states.
package pulse_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam logic [2:0] ADDR_PER      = 3'd0;
    localparam logic [2:0] ADDR_P1WID    = 3'd1;
    localparam logic [2:0] ADDR_DEL      = 3'd2;
    localparam logic [2:0] ADDR_P2WID    = 3'd3;
    localparam logic [2:0] ADDR_P_BL     = 3'd4;
    localparam logic [2:0] ADDR_P_BL_OFF = 3'd5;
    localparam logic [2:0] ADDR_FLAGS    = 3'd6;
    localparam logic [2:0] ADDR_CTRL     = 3'd7;

    localparam int FLAG_PU     = 0;
    localparam int FLAG_CP     = 1;
    localparam int FLAG_BL     = 2;
    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_IMM    = 1;

    localparam logic [31:0] DEF_PER      = 32'd200_000;
    localparam logic [31:0] DEF_P1WID    = 32'd100;
    localparam logic [31:0] DEF_DEL      = 32'd2_000;
    localparam logic [31:0] DEF_P2WID    = 32'd200;
    localparam logic [7:0]  DEF_P_BL     = 8'd100;
    localparam logic [15:0] DEF_P_BL_OFF = 16'd1_000;
    localparam logic        DEF_PU       = 1'b1;
    localparam logic        DEF_CP       = 1'b0;
    localparam logic        DEF_BL       = 1'b1;

    // Frame decoder states; the encoding is visible on the loader's dbg_state port.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_RESP = 3'd4
    } frame_state_t;

    typedef struct packed {
        logic [31:0] per;
        logic [31:0] p1wid;
        logic [31:0] del;
        logic [31:0] p2wid;
        logic [7:0]  p_bl;
        logic [15:0] p_bl_off;
        logic        pu;
        logic        cp;
        logic        bl;
    } param_set_t;

    function automatic param_set_t default_params();
        param_set_t p;
        p.per      = DEF_PER;
        p.p1wid    = DEF_P1WID;
        p.del      = DEF_DEL;
        p.p2wid    = DEF_P2WID;
        p.p_bl     = DEF_P_BL;
        p.p_bl_off = DEF_P_BL_OFF;
        p.pu       = DEF_PU;
        p.cp       = DEF_CP;
        p.bl       = DEF_BL;
        return p;
    endfunction

endpackage

// File: rtl/param_bank.sv
// Shadow and live parameter registers. Writes land only in shadow; a commit
// copies the whole shadow set to live, either at a period boundary or immediately.
module param_bank
    import pulse_pkg::*;
(
    input  logic        clk_pll,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        commit,
    input  logic        commit_imm,
    input  logic        period_start,
    output param_set_t  live,
    output logic        pending
);

    param_set_t shadow_q;
    param_set_t live_q;
    logic       pending_q;
    logic       imm_q;
    logic       transfer;

    assign transfer = pending_q && (imm_q || period_start);
    assign live     = live_q;
    assign pending  = pending_q;

    always_ff @(posedge clk_pll) begin
        if (reset) begin
            shadow_q  <= default_params();
            live_q    <= default_params();
            pending_q <= 1'b0;
            imm_q     <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_addr)
                    ADDR_PER:      shadow_q.per      <= wr_data;
                    ADDR_P1WID:    shadow_q.p1wid    <= wr_data;
                    ADDR_DEL:      shadow_q.del      <= wr_data;
                    ADDR_P2WID:    shadow_q.p2wid    <= wr_data;
                    ADDR_P_BL:     shadow_q.p_bl     <= wr_data[7:0];
                    ADDR_P_BL_OFF: shadow_q.p_bl_off <= wr_data[15:0];
                    ADDR_FLAGS: begin
                        shadow_q.pu <= wr_data[FLAG_PU];
                        shadow_q.cp <= wr_data[FLAG_CP];
                        shadow_q.bl <= wr_data[FLAG_BL];
                    end
                    default: ;
                endcase
            end
            // Non-blocking read of shadow_q: a same-cycle write stays in shadow only.
            if (transfer) begin
                live_q <= shadow_q;
            end
            if (commit) begin
                pending_q <= 1'b1;
                imm_q     <= (imm_q && !transfer) || commit_imm;
            end else if (transfer) begin
                pending_q <= 1'b0;
                imm_q     <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pulse_param_loader.sv
// Decodes 7-byte framed register writes from the UART byte stream into param_bank
// and answers each frame with one ACK/NAK byte.
module pulse_param_loader
    import pulse_pkg::*;
#(
    parameter logic [31:0] TIMEOUT = 32'd2_000_000,
    parameter logic [7:0]  SOF     = SOF_BYTE,
    parameter logic [7:0]  ACK     = ACK_BYTE,
    parameter logic [7:0]  NAK     = NAK_BYTE
) (
    input  logic        clk_pll,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        period_start,
    output logic [31:0] per,
    output logic [31:0] p1wid,
    output logic [31:0] del,
    output logic [31:0] p2wid,
    output logic [7:0]  p_bl,
    output logic [15:0] p_bl_off,
    output logic        pu,
    output logic        cp,
    output logic        bl,
    output logic        pending,
    output logic [7:0]  err_cnt,
    output logic [2:0]  dbg_state
);

    // tx handshake: tx_valid stays high with tx_data stable until a cycle with
    // tx_ready=1; that cycle is the transfer and tx_valid drops on the next one.
    frame_state_t state_q, state_d;
    logic [7:0]   addr_q, addr_d;
    logic [31:0]  data_q, data_d;
    logic [1:0]   idx_q, idx_d;
    logic [7:0]   csum_q, csum_d;
    logic [31:0]  gap_q, gap_d;
    logic [7:0]   tx_data_q, tx_data_d;
    logic [7:0]   err_q;
    logic         err_inc;
    logic         wr_en;
    logic         commit;
    logic         commit_imm;
    logic         in_frame;
    param_set_t   live;

    assign in_frame  = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign tx_valid  = (state_q == ST_RESP);
    assign tx_data   = tx_data_q;
    assign err_cnt   = err_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        tx_data_d  = tx_data_q;
        err_inc    = 1'b0;
        wr_en      = 1'b0;
        commit     = 1'b0;
        commit_imm = 1'b0;
        gap_d      = (in_frame && !rx_valid) ? gap_q + 32'd1 : 32'd0;
        case (state_q)
            ST_IDLE: if (rx_valid && rx_data == SOF) state_d = ST_ADDR;
            ST_ADDR: if (rx_valid) begin
                addr_d  = rx_data;
                csum_d  = rx_data;
                idx_d   = 2'd0;
                state_d = ST_DATA;
            end
            ST_DATA: if (rx_valid) begin
                data_d[{idx_q, 3'b000} +: 8] = rx_data;
                csum_d = csum_q ^ rx_data;
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = ST_CSUM;
            end
            ST_CSUM: if (rx_valid) begin
                if (rx_data == csum_q && addr_q <= 8'd7) begin
                    tx_data_d = ACK;
                    if (addr_q[2:0] == ADDR_CTRL) begin
                        commit     = data_q[CTRL_COMMIT];
                        commit_imm = data_q[CTRL_COMMIT] && data_q[CTRL_IMM];
                    end else begin
                        wr_en = 1'b1;
                    end
                end else begin
                    tx_data_d = NAK;
                    err_inc   = 1'b1;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                err_inc = rx_valid;
                if (tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A stalled host abandons the partial frame without a response.
        if (in_frame && !rx_valid && gap_q >= TIMEOUT) begin
            state_d = ST_IDLE;
            err_inc = 1'b1;
        end
    end

    always_ff @(posedge clk_pll) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= 8'd0;
            data_q    <= 32'd0;
            idx_q     <= 2'd0;
            csum_q    <= 8'd0;
            gap_q     <= 32'd0;
            tx_data_q <= 8'd0;
            err_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            gap_q     <= gap_d;
            tx_data_q <= tx_data_d;
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
    end

    param_bank u_bank (
        .clk_pll      (clk_pll),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (addr_q[2:0]),
        .wr_data      (data_q),
        .commit       (commit),
        .commit_imm   (commit_imm),
        .period_start (period_start),
        .live         (live),
        .pending      (pending)
    );

    assign per      = live.per;
    assign p1wid    = live.p1wid;
    assign del      = live.del;
    assign p2wid    = live.p2wid;
    assign p_bl     = live.p_bl;
    assign p_bl_off = live.p_bl_off;
    assign pu       = live.pu;
    assign cp       = live.cp;
    assign bl       = live.bl;

endmodule

// File: doc/pulse_param_loader.md
# pulse_param_loader

Host-side parameter writer for the `pulses` generator. It consumes a byte stream from the existing UART receiver and decodes framed register writes into a shadow bank. On an explicit commit it transfers the whole bank to the live parameter outputs, aligned to a pulse-period boundary so `pulses` never sees a half-updated set. Each frame is acknowledged with one byte back to the host.

## Interface
Parameters:
- `TIMEOUT`, 32'd2_000_000: inter-byte gap in clk_pll cycles (10 ms) that aborts a partial frame.
- `SOF`, 8'hA5: start-of-frame byte.
- `ACK` / `NAK`, 8'h06 / 8'h15: response bytes.

Ports (one clock `clk_pll`; `reset` synchronous, active-high):
- `clk_pll` in 1: 200 MHz PLL clock.
- `reset` in 1: sync, active-high.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: 1-cycle strobe, `rx_data` valid.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: held until `tx_ready`.
- `tx_ready` in 1: UART transmitter accepts `tx_data`.
- `period_start` in 1: 1-cycle strobe at counter wrap of `pulses`, driven from the rising edge of `sync_on`.
- `per`, `p1wid`, `del`, `p2wid` out 32 each: live timing, in clk_pll cycles.
- `p_bl` out 8: live block-window offset.
- `p_bl_off` out 16: live block-window width.
- `pu`, `cp`, `bl` out 1 each: live pump-enable, mode, and block-enable.
- `pending` out 1: a commit is waiting for `period_start`.
- `err_cnt` out 8: saturating count of rejected frames.

## Operation
- Frame is 7 bytes: SOF, ADDR, D0..D3 (LSB first), CSUM. CSUM = ADDR ^ D0 ^ D1 ^ D2 ^ D3.
- Address map:
  - 0 `per`, 1 `p1wid`, 2 `del`, 3 `p2wid`.
  - 4 `p_bl` (D0).
  - 5 `p_bl_off` (D1:D0).
  - 6 flags: D0[0]=`pu`, D0[1]=`cp`, D0[2]=`bl`.
  - 7 control: D0[0]=commit; D0[1]=immediate. Immediate applies on the next cycle; without it, the commit waits for `period_start`.
  - Unused data bits are ignored.
- FSM states:
  - IDLE: SOF goes to ADDR; any other byte is discarded silently.
  - ADDR: any byte is latched, then go to DATA. A 2-bit index counts D0..D3.
  - DATA: after D3, go to CSUM.
  - CSUM: on a match with ADDR ≤ 7, perform the write or control action and load ACK. Otherwise load NAK and increment `err_cnt` (saturates at 255). Go to RESP.
  - RESP: assert `tx_valid` until `tx_ready`, then go to IDLE. `rx_valid` strobes received in RESP are dropped and each increments `err_cnt`.
- Timeout: a gap counter resets on each `rx_valid` while in ADDR/DATA/CSUM. When it reaches `TIMEOUT`, go to IDLE with no response and increment `err_cnt`.
- Shadow writes never touch the live outputs. A commit copies all 9 shadow fields to the live outputs in one cycle.
- Commit sets `pending`.
  - Transfer happens on the first cycle with `period_start`=1 and `pending`=1, or on the next cycle if immediate. `pending` clears on the transfer.
  - A commit while already pending keeps a single pending request. The bank copied is whatever shadow holds at transfer time.
- Shadow write and transfer in the same cycle: the transfer takes the pre-write shadow value. The new write stays in shadow.

## Timing
- Reset values, shadow and live:
  - `per`=200000, `p1wid`=100, `del`=2000, `p2wid`=200.
  - `p_bl`=100, `p_bl_off`=1000.
  - `pu`=1, `cp`=0, `bl`=1.
- Reset values, status and handshake: `pending`=0, `err_cnt`=0, `tx_valid`=0, `tx_data`=0, FSM in IDLE.
- Reset mid-frame or mid-RESP: immediate return to IDLE with defaults. A queued response is abandoned.
- `tx_valid` rises the cycle after the CSUM byte's `rx_valid`.
- Live outputs change the cycle after the qualifying `period_start`, which is the first cycle of counter 1 in `pulses`. Immediate commit updates 2 cycles after the CSUM strobe.
- All outputs are registered. There is no combinational path from `rx_*` or `period_start`.

## Structure
- Shared package `pulse_pkg`: address constants (`ADDR_PER`…`ADDR_CTRL`), flag bit indices, reset defaults, and SOF/ACK/NAK. `pulses` and its test bench reuse the same defaults.
- Sub-module `param_bank`: shadow and live registers, pending logic, and the transfer. The top level keeps the frame FSM, timeout, and response handshake.

## Test plan
- Write addr 1 = 500 with a good CSUM, then control 0x01, then pulse `period_start` → ACK twice; `pending`=1 until the strobe; `p1wid`=500 the cycle after; other outputs keep their defaults.
- Bad CSUM on addr 0 → NAK, `err_cnt`=1, shadow `per` unchanged (verified by a later commit showing 200000).
- Stall 3 bytes into a frame for `TIMEOUT` cycles → no response, `err_cnt`+1. The next full frame is accepted.
- Immediate commit (0x03) of addr 6 = 0x02 → `cp`=1, `pu`=0, `bl`=0 two cycles after CSUM, with no `period_start`.
- Hold `tx_ready`=0 for 100 cycles with 2 extra `rx_valid` strobes → `tx_valid` held stable with ACK, `err_cnt`+2, return to IDLE after the handshake.
- Assert `reset` during D2 of a frame → outputs at defaults, FSM in IDLE. A fresh frame gets ACK.
